count_watch: RTL and testbench
==============================

Name: count_watch

Overview:
- Downstream monitor for the 4-bit loadable up-counter. Samples the counter output `q` every clock and classifies each step as increment, wrap, hold, or jump (load/reset).
- Produces single-cycle event pulses, a saturating wrap tally, a value-match pulse and a stall flag.
- Used for counter health checking and for divided-tick generation in the lab top level.

Parameters:
- WIDTH, 4, width of the observed counter value.
- WRAP_W, 8, width of the wrap tally.
- STALL_CYC, 4, consecutive unchanged samples (>=2) needed to flag a stall.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  asynchronous, active-low reset (assert 0, release 1).
- q_in  input  WIDTH  counter value being observed.
- match_val  input  WIDTH  compare value.
- match_en  input  1  enables match detection.
- wrap_cnt_clr  input  1  synchronous clear of wrap_cnt.
- prev_q  output  WIDTH  last sampled q_in.
- wrap_pulse  output  1  one-cycle pulse: step from all-ones to 0.
- jump_pulse  output  1  one-cycle pulse: step that is neither +1 nor hold.
- match_pulse  output  1  one-cycle pulse: q_in newly equals match_val.
- stall  output  1  level: q_in unchanged for STALL_CYC samples.
- wrap_cnt  output  WRAP_W  saturating count of wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port `reset`. While reset=0 all outputs are 0 and state=SYNC; the stall counter is 0. All outputs are registered.
- SYNC: the first clk edge after reset release captures q_in into prev_q, raises no pulses, and moves to TRACK.
- TRACK, at each edge, comparing q_in (n) against prev_q (p):
  - n == p+1 mod 2^WIDTH: normal step. If p == all-ones, also raise wrap_pulse and increment wrap_cnt.
  - n == p: hold; stall counter increments, saturating at STALL_CYC.
  - anything else: jump_pulse=1 and the stall counter clears.
  - prev_q <= n on every edge.
- Stall: when the stall counter reaches STALL_CYC-1 and the current sample is another hold, stall=1 on that edge and state moves to STALL. With STALL_CYC=4, stall rises at the edge sampling the 4th identical value (3 holds after the first).
- STALL: stall stays 1 while n == p. On the first change, stall=0 on that edge and state returns to TRACK. The change is classified by the same rules, so it can raise wrap or jump.
- match_pulse: 1 when match_en=1, n == match_val and n != p, in TRACK or STALL. Never raised in SYNC and never repeated during a hold.
- Pulse duration: wrap_pulse, jump_pulse and match_pulse are high for exactly one cycle (the cycle after the triggering edge) unless retriggered.
- wrap_cnt: saturates at 2^WRAP_W-1 and never rolls over. When wrap_cnt_clr and a wrap occur on the same edge, wrap_cnt becomes 1. A clear alone gives 0.
- Simultaneous events: match and wrap can pulse together (match_val=0 on a wrap). Match and jump can pulse together (a load onto match_val).
- Reset mid-operation: immediately clears everything and returns to SYNC. The counter's own reset-to-0 seen after release is therefore not reported as a jump.

Optional Feature:
- Macro COUNT_WATCH_DOWN_EN.
- Defined:
  - n == p-1 mod 2^WIDTH is treated as a normal step, not a jump.
  - A step from 0 to all-ones raises wrap_pulse and increments wrap_cnt.
  - Adds output port `down_step` (1 bit, registered, reset 0), which reflects the direction of the last non-hold step (1 = down).
- Undefined: decrements are jumps, there is no down_step port, and only all-ones->0 is a wrap.

Test Plan:
- Reset then free-run: reset=0 for 2 cycles, counter runs 0,1,2…15,0 -> no pulses on the first sample; wrap_pulse exactly once at 15->0; wrap_cnt=1; jump_pulse never.
- Load: counter at 3 loads 13 -> jump_pulse one cycle; 13->14->15->0 -> wrap_pulse; wrap_cnt increments.
- Hold/stall (STALL_CYC=4): q_in held at 6 for 6 cycles, then 7 -> stall rises on the 4th sample of 6 and falls on the edge sampling 7; no jump.
- Match: match_en=1, match_val=9, counter passes 9 then holds at 9 for 3 cycles -> single match_pulse; with match_en=0, none.
- Wrap saturation/clear (WRAP_W=2): 5 wraps -> wrap_cnt=3. Assert wrap_cnt_clr on the same edge as a 15->0 step -> wrap_cnt=1.
- Async reset mid-stall: reset=0 between edges while stall=1 -> all outputs 0 immediately. After release the first sample raises no pulse.

Source files
------------

// File: rtl/count_watch.sv
// count_watch: samples an observed counter every clock and classifies each step (increment, wrap, hold, jump) into registered pulses, a wrap tally and a stall flag.
// Optional build macro COUNT_WATCH_DOWN_EN accepts -1 steps as normal (0 -> all-ones wraps) and adds the down_step output.
module count_watch #(
  parameter int WIDTH     = 4,
  parameter int WRAP_W    = 8,
  parameter int STALL_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  q_in,
  input  logic [WIDTH-1:0]  match_val,
  input  logic              match_en,
  input  logic              wrap_cnt_clr,
  output logic [WIDTH-1:0]  prev_q,
  output logic              wrap_pulse,
  output logic              jump_pulse,
  output logic              match_pulse,
  output logic              stall,
  output logic [WRAP_W-1:0] wrap_cnt
`ifdef COUNT_WATCH_DOWN_EN
  ,
  output logic              down_step
`endif
);

  localparam int CW = $clog2(STALL_CYC + 1);

  typedef enum logic [1:0] {SYNC, TRACK, STALL} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;

  logic [WIDTH-1:0]  w_p_inc;
  logic              w_hold;
  logic              w_up;
  logic              w_dn;
  logic              w_wrap;
  logic              w_jump;
  logic              w_match;
  logic              w_stall_hit;
  logic [CW-1:0]     w_cnt_inc;
  logic [WRAP_W-1:0] w_wrap_cnt_nxt;

  assign w_p_inc = prev_q + WIDTH'(1);
  assign w_hold  = (q_in == prev_q);
  assign w_up    = (q_in == w_p_inc);

`ifdef COUNT_WATCH_DOWN_EN
  logic [WIDTH-1:0] w_p_dec;
  assign w_p_dec = prev_q - WIDTH'(1);
  assign w_dn    = (q_in == w_p_dec);
`else
  assign w_dn    = 1'b0;
`endif

  assign w_wrap  = (w_up && (prev_q == {WIDTH{1'b1}})) || (w_dn && (prev_q == '0));
  assign w_jump  = !w_hold && !w_up && !w_dn;
  assign w_match = match_en && (q_in == match_val) && !w_hold;

  // r_cnt counts holds since the last change; the first sample of a run is not a hold
  assign w_cnt_inc   = (r_cnt == CW'(STALL_CYC)) ? r_cnt : r_cnt + CW'(1);
  assign w_stall_hit = w_hold && (w_cnt_inc >= CW'(STALL_CYC - 1));

  always_comb begin
    w_wrap_cnt_nxt = wrap_cnt;
    if (wrap_cnt_clr) begin
      w_wrap_cnt_nxt = w_wrap ? WRAP_W'(1) : '0;
    end else if (w_wrap && (wrap_cnt != {WRAP_W{1'b1}})) begin
      w_wrap_cnt_nxt = wrap_cnt + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SYNC;
      r_cnt       <= '0;
      prev_q      <= '0;
      wrap_pulse  <= 1'b0;
      jump_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      stall       <= 1'b0;
      wrap_cnt    <= '0;
`ifdef COUNT_WATCH_DOWN_EN
      down_step   <= 1'b0;
`endif
    end else begin
      prev_q <= q_in;
      case (r_state)
        SYNC: begin
          wrap_pulse  <= 1'b0;
          jump_pulse  <= 1'b0;
          match_pulse <= 1'b0;
          stall       <= 1'b0;
          r_cnt       <= '0;
          wrap_cnt    <= wrap_cnt_clr ? '0 : wrap_cnt;
          r_state     <= TRACK;
        end
        default: begin
          wrap_pulse  <= w_wrap;
          jump_pulse  <= w_jump;
          match_pulse <= w_match;
          wrap_cnt    <= w_wrap_cnt_nxt;
          if (w_hold) begin
            r_cnt   <= w_cnt_inc;
            stall   <= w_stall_hit;
            r_state <= w_stall_hit ? STALL : TRACK;
          end else begin
            r_cnt   <= '0;
            stall   <= 1'b0;
            r_state <= TRACK;
          end
`ifdef COUNT_WATCH_DOWN_EN
          if (w_up) begin
            down_step <= 1'b0;
          end else if (w_dn) begin
            down_step <= 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_watch.sv
// Bench for count_watch: run-length/arithmetic reference model compared every cycle, plus directed literal checks.
module tb_count_watch;

  localparam int WIDTH     = 4;
  localparam int WRAP_W    = 2;
  localparam int STALL_CYC = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [WIDTH-1:0]  q_in = '0;
  logic [WIDTH-1:0]  match_val = '0;
  logic              match_en = 1'b0;
  logic              wrap_cnt_clr = 1'b0;
  logic [WIDTH-1:0]  prev_q;
  logic              wrap_pulse;
  logic              jump_pulse;
  logic              match_pulse;
  logic              stall;
  logic [WRAP_W-1:0] wrap_cnt;
`ifdef COUNT_WATCH_DOWN_EN
  logic              down_step;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_wrap  = 0;
  int n_jump  = 0;
  int n_match = 0;
  int n_stall_rise = 0;
  logic stall_d = 1'b0;

  count_watch #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .STALL_CYC(STALL_CYC)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .match_val(match_val), .match_en(match_en),
    .wrap_cnt_clr(wrap_cnt_clr), .prev_q(prev_q), .wrap_pulse(wrap_pulse),
    .jump_pulse(jump_pulse), .match_pulse(match_pulse), .stall(stall), .wrap_cnt(wrap_cnt)
`ifdef COUNT_WATCH_DOWN_EN
    , .down_step(down_step)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks run length of identical samples and the wrap tally.
  bit m_sync = 0;
  int m_p = 0;
  int m_run = 0;
  int m_tally = 0;
  int e_prev = 0, e_wrap = 0, e_jump = 0, e_match = 0, e_stall = 0, e_wcnt = 0;
  int e_down = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sync = 0; m_p = 0; m_run = 0; m_tally = 0;
      e_prev = 0; e_wrap = 0; e_jump = 0; e_match = 0; e_stall = 0; e_wcnt = 0; e_down = 0;
    end else if (!m_sync) begin
      m_sync = 1;
      m_p = int'(q_in);
      m_run = 1;
      if (wrap_cnt_clr) m_tally = 0;
      e_prev = m_p; e_wrap = 0; e_jump = 0; e_match = 0; e_stall = 0; e_wcnt = m_tally;
    end else begin
      int n;
      bit up, dn, hold, wrap;
      n    = int'(q_in);
      hold = (n == m_p);
      up   = (n == (m_p + 1) % 16);
      dn   = 0;
`ifdef COUNT_WATCH_DOWN_EN
      dn   = (n == (m_p + 15) % 16);
`endif
      wrap = (up && m_p == 15) || (dn && m_p == 0);
      if (up) e_down = 0;
      if (dn) e_down = 1;
      e_wrap  = int'(wrap);
      e_jump  = int'(!hold && !up && !dn);
      e_match = int'(match_en && n == int'(match_val) && !hold);
      m_run   = hold ? ((m_run < 100) ? m_run + 1 : m_run) : 1;
      e_stall = int'(m_run >= STALL_CYC);
      if (wrap_cnt_clr) m_tally = wrap ? 1 : 0;
      else if (wrap && m_tally < (1 << WRAP_W) - 1) m_tally = m_tally + 1;
      e_wcnt = m_tally;
      m_p    = n;
      e_prev = n;
    end
  end

  // Single per-cycle compare process, away from the active edge.
  always @(negedge clk) begin
    chk("prev_q", int'(prev_q), e_prev);
    chk("wrap_pulse", int'(wrap_pulse), e_wrap);
    chk("jump_pulse", int'(jump_pulse), e_jump);
    chk("match_pulse", int'(match_pulse), e_match);
    chk("stall", int'(stall), e_stall);
    chk("wrap_cnt", int'(wrap_cnt), e_wcnt);
`ifdef COUNT_WATCH_DOWN_EN
    chk("down_step", int'(down_step), e_down);
`endif
    n_wrap  += int'(wrap_pulse);
    n_jump  += int'(jump_pulse);
    n_match += int'(match_pulse);
    if (stall && !stall_d) n_stall_rise++;
    stall_d = stall;
  end

  task automatic apply(input logic [WIDTH-1:0] v);
    q_in = v;
    @(negedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_wrap = 0; n_jump = 0; n_match = 0; n_stall_rise = 0;
  endtask

  initial begin
    repeat (2) begin @(negedge clk); #1; end
    chk("reset prev_q", int'(prev_q), 0);
    chk("reset wrap_cnt", int'(wrap_cnt), 0);

    // Free run 0..15,0
    reset = 1'b1;
    clr_counts();
    apply(4'd0);
    chk("first sample pulses", int'({wrap_pulse, jump_pulse, match_pulse}), 0);
    chk("first sample prev_q", int'(prev_q), 0);
    for (int v = 1; v <= 15; v++) apply(4'(v));
    apply(4'd0);
    chk("freerun wraps", n_wrap, 1);
    chk("freerun jumps", n_jump, 0);
    chk("freerun wrap_cnt", int'(wrap_cnt), 1);

    // Load 3 -> 13
    clr_counts();
    apply(4'd1); apply(4'd2); apply(4'd3);
    apply(4'd13);
    chk("load jump", int'(jump_pulse), 1);
    apply(4'd14);
    chk("load jump one cycle", int'(jump_pulse), 0);
    apply(4'd15); apply(4'd0);
    chk("load wrap", int'(wrap_pulse), 1);
    chk("load wrap_cnt", int'(wrap_cnt), 2);
    chk("load jumps", n_jump, 1);

    // Hold at 6 for 6 samples, then 7
    for (int v = 1; v <= 6; v++) apply(4'(v));
    clr_counts();
    apply(4'd6); apply(4'd6);
    chk("stall after 3 samples", int'(stall), 0);
    apply(4'd6);
    chk("stall at 4th sample", int'(stall), 1);
    apply(4'd6); apply(4'd6);
    chk("stall held", int'(stall), 1);
    apply(4'd7);
    chk("stall falls", int'(stall), 0);
    chk("hold jumps", n_jump, 0);
    chk("stall rises", n_stall_rise, 1);

    // Match on 9, then hold at 9
    match_val = 4'd9; match_en = 1'b1;
    clr_counts();
    apply(4'd8); apply(4'd9);
    chk("match pulse", int'(match_pulse), 1);
    repeat (3) apply(4'd9);
    chk("match single", n_match, 1);
    match_en = 1'b0;
    clr_counts();
    for (int v = 10; v <= 25; v++) apply(4'(v % 16));
    chk("match disabled", n_match, 0);
    chk("wrap_cnt 3 wraps", int'(wrap_cnt), 3);

    // Match with wrap, saturation
    match_val = 4'd0; match_en = 1'b1;
    for (int v = 10; v <= 15; v++) apply(4'(v));
    apply(4'd0);
    chk("match+wrap match", int'(match_pulse), 1);
    chk("match+wrap wrap", int'(wrap_pulse), 1);
    chk("wrap_cnt sat 4", int'(wrap_cnt), 3);
    for (int v = 1; v <= 16; v++) apply(4'(v % 16));
    chk("wrap_cnt sat 5", int'(wrap_cnt), 3);

    // Clear coincident with wrap, then clear alone
    match_en = 1'b0;
    for (int v = 1; v <= 15; v++) apply(4'(v));
    wrap_cnt_clr = 1'b1;
    apply(4'd0);
    chk("clr+wrap", int'(wrap_cnt), 1);
    apply(4'd1);
    chk("clr alone", int'(wrap_cnt), 0);
    wrap_cnt_clr = 1'b0;

    // Load onto match value
    match_val = 4'd12; match_en = 1'b1;
    apply(4'd12);
    chk("match+jump jump", int'(jump_pulse), 1);
    chk("match+jump match", int'(match_pulse), 1);
    match_en = 1'b0;

    // Async reset while stalled
    apply(4'd13); apply(4'd14); apply(4'd15); apply(4'd0);
    for (int v = 1; v <= 5; v++) apply(4'(v));
    repeat (3) apply(4'd5);
    chk("pre-reset stall", int'(stall), 1);
    chk("pre-reset wrap_cnt", int'(wrap_cnt), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async stall", int'(stall), 0);
    chk("async prev_q", int'(prev_q), 0);
    chk("async wrap_cnt", int'(wrap_cnt), 0);
    chk("async pulses", int'({wrap_pulse, jump_pulse, match_pulse}), 0);
    @(negedge clk); #1;
    reset = 1'b1;
    apply(4'd9);
    chk("post-reset prev_q", int'(prev_q), 9);
    chk("post-reset pulses", int'({wrap_pulse, jump_pulse, match_pulse, stall}), 0);
    apply(4'd10);
    chk("post-reset step", int'(jump_pulse), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
